// File: rtl/rl_fifo_1r1w_ctrl.sv
// rl_fifo_1r1w_ctrl
// First-word-fall-through FIFO controller in front of an external 1R1W RAM
// with a 1-cycle registered read. A 2-entry output buffer (head + skid)
// hides the read latency so a word can be pushed and popped every cycle.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS = 4,
  parameter int DBITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DBITS-1:0]       din_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   empty_o,
  output logic [ABITS+1:0]       count_o,
  output logic                   ovf_o,
  output logic                   unf_o,
  output logic [ABITS-1:0]       mem_waddr_o,
  output logic [DBITS-1:0]       mem_din_o,
  output logic                   mem_we_o,
  output logic [(DBITS+7)/8-1:0] mem_be_o,
  output logic [ABITS-1:0]       mem_raddr_o,
  input  logic [DBITS-1:0]       mem_dout_i
);

  localparam int PW  = ABITS + 1;
  localparam int BEW = (DBITS + 7) / 8;

  // Registered state
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_rd_pend;
  logic [1:0]       r_buf_cnt;
  logic [DBITS-1:0] r_head;
  logic [DBITS-1:0] r_skid;
  logic             r_ovf;
  logic             r_unf;

  // Combinational helpers
  logic [PW-1:0]    w_ram_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_issue;
  logic [2:0]       w_occ;
  logic [2:0]       w_limit;
  logic [1:0]       w_buf_cnt_nxt;
  logic [DBITS-1:0] w_head_nxt;
  logic [DBITS-1:0] w_skid_nxt;

  // Flags are derived from registered pointers only, so a same-cycle pop
  // never frees RAM space for a same-cycle push.
  assign w_ram_cnt  = r_wptr - r_rptr;
  assign w_full     = (w_ram_cnt == {1'b1, {ABITS{1'b0}}});
  assign w_empty    = (r_buf_cnt == 2'd0);
  assign w_push_acc = push_i & ~w_full & ~clear_i;
  assign w_pop_acc  = pop_i & ~w_empty;

  // A read is only launched when the output buffer is guaranteed a free slot
  // by the time the word returns; buf_cnt + rd_pend never exceeds 2.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend};
  assign w_limit = 3'd2 + {2'b00, w_pop_acc};
  assign w_issue = (w_ram_cnt != {PW{1'b0}}) & (w_occ < w_limit);

  // Output buffer next state: remove head on pop, then append the returning RAM word
  always_comb begin
    w_buf_cnt_nxt = r_buf_cnt;
    w_head_nxt    = r_head;
    w_skid_nxt    = r_skid;
    case ({w_pop_acc, r_rd_pend})
      2'b01: begin
        if (r_buf_cnt == 2'd0) begin
          w_head_nxt    = mem_dout_i;
          w_buf_cnt_nxt = 2'd1;
        end else begin
          w_skid_nxt    = mem_dout_i;
          w_buf_cnt_nxt = 2'd2;
        end
      end
      2'b10: begin
        if (r_buf_cnt == 2'd2) begin
          w_head_nxt = r_skid;
        end else begin
          w_head_nxt = r_head;
        end
        w_buf_cnt_nxt = r_buf_cnt - 2'd1;
      end
      2'b11: begin
        if (r_buf_cnt == 2'd2) begin
          w_head_nxt = r_skid;
          w_skid_nxt = mem_dout_i;
        end else begin
          w_head_nxt = mem_dout_i;
        end
        w_buf_cnt_nxt = r_buf_cnt;
      end
      default: begin
        w_buf_cnt_nxt = r_buf_cnt;
      end
    endcase
  end

  // Pointer, in-flight flag, buffer and pulse registers; clear_i restores reset state but keeps dout_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= {PW{1'b0}};
      r_rptr    <= {PW{1'b0}};
      r_rd_pend <= 1'b0;
      r_buf_cnt <= 2'd0;
      r_head    <= {DBITS{1'b0}};
      r_skid    <= {DBITS{1'b0}};
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (clear_i) begin
      r_wptr    <= {PW{1'b0}};
      r_rptr    <= {PW{1'b0}};
      r_rd_pend <= 1'b0;
      r_buf_cnt <= 2'd0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wptr <= r_wptr + {{ABITS{1'b0}}, 1'b1};
      end
      if (w_issue) begin
        r_rptr <= r_rptr + {{ABITS{1'b0}}, 1'b1};
      end
      r_rd_pend <= w_issue;
      r_buf_cnt <= w_buf_cnt_nxt;
      r_head    <= w_head_nxt;
      r_skid    <= w_skid_nxt;
      r_ovf     <= push_i & w_full;
      r_unf     <= pop_i & w_empty;
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign dout_o  = r_head;
  assign ovf_o   = r_ovf;
  assign unf_o   = r_unf;
  assign count_o = {1'b0, w_ram_cnt}
                 + {{PW{1'b0}}, r_rd_pend}
                 + {{ABITS{1'b0}}, r_buf_cnt};

  // RAM ports. The read address is the read pointer itself; a read of the
  // location being written only happens when ram_cnt is zero, and that
  // returned word is never captured because no read is issued then.
  assign mem_waddr_o = r_wptr[ABITS-1:0];
  assign mem_din_o   = din_i;
  assign mem_we_o    = w_push_acc;
  assign mem_be_o    = {BEW{1'b1}};
  assign mem_raddr_o = r_rptr[ABITS-1:0];

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Bench for rl_fifo_1r1w_ctrl (ABITS=2, capacity 6) with a behavioural RAM
// and a queue-based reference model of the FIFO contents.
module tb_rl_fifo_1r1w_ctrl;
  localparam int ABITS = 2;
  localparam int DBITS = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [DBITS-1:0] din_i = 32'h0;
  logic full_o, empty_o, ovf_o, unf_o, mem_we_o;
  logic [DBITS-1:0] dout_o, mem_din_o, mem_dout_i;
  logic [ABITS+1:0] count_o;
  logic [ABITS-1:0] mem_waddr_o, mem_raddr_o;
  logic [3:0] mem_be_o;

  logic [DBITS-1:0] ram [0:3];
  logic [DBITS-1:0] q [$];
  logic exp_ovf, exp_unf;
  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .push_i(push_i), .din_i(din_i),
    .full_o(full_o), .pop_i(pop_i), .dout_o(dout_o), .empty_o(empty_o), .count_o(count_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .mem_waddr_o(mem_waddr_o), .mem_din_o(mem_din_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_raddr_o(mem_raddr_o), .mem_dout_i(mem_dout_i)
  );

  // RAM: registered read, no write-to-read bypass
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_waddr_o] <= mem_din_o;
    mem_dout_i <= ram[mem_raddr_o];
  end

  // One clock of stimulus; updates the reference queue by the FIFO rules.
  // Entered and left #1 after a rising edge.
  task automatic drive(input logic p, input logic [DBITS-1:0] d, input logic po, input logic c);
    push_i = p; din_i = d; pop_i = po; clear_i = c;
    #2;
    exp_ovf = !c && p && full_o;
    exp_unf = !c && po && empty_o;
    if (c) begin
      q.delete();
    end else begin
      if (po && !empty_o && q.size() > 0) void'(q.pop_front());
      if (p && !full_o) q.push_back(d);
    end
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got=%0b exp=1", empty_o); end
    tests_run++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full got=%0b exp=0", full_o); end
    tests_run++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    tests_run++; if (dout_o !== 32'h0) begin fails++; $display("FAIL reset_dout got=%0h exp=0", dout_o); end
    tests_run++; if ({ovf_o, unf_o} !== 2'b00) begin fails++; $display("FAIL reset_pulses got=%0b exp=00", {ovf_o, unf_o}); end
    rst_ni = 1'b1;
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL single_empty_n1 got=%0b exp=1", empty_o); end
    tests_run++; if (count_o !== 4'd1) begin fails++; $display("FAIL single_count_n1 got=%0d exp=1", count_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL single_empty_n2 got=%0b exp=1", empty_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (empty_o !== 1'b0) begin fails++; $display("FAIL single_empty_n3 got=%0b exp=0", empty_o); end
    tests_run++; if (dout_o !== 32'hA1) begin fails++; $display("FAIL single_dout got=%0h exp=a1", dout_o); end
    tests_run++; if (count_o !== 4'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", count_o); end
  endtask

  task automatic test_fill();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    tests_run++; if (full_o !== 1'b1) begin fails++; $display("FAIL fill_full got=%0b exp=1", full_o); end
    tests_run++; if (count_o !== 4'd6) begin fails++; $display("FAIL fill_count got=%0d exp=6", count_o); end
    tests_run++; if (mem_be_o !== 4'hF) begin fails++; $display("FAIL fill_be got=%0h exp=f", mem_be_o); end
    push_i = 1'b1; din_i = 32'h7; #1;
    tests_run++; if (mem_we_o !== 1'b0) begin fails++; $display("FAIL fill_we_when_full got=%0b exp=0", mem_we_o); end
    drive(1'b1, 32'h7, 1'b0, 1'b0);
    tests_run++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL fill_ovf got=%0b exp=1", ovf_o); end
    tests_run++; if (count_o !== 4'd6) begin fails++; $display("FAIL fill_count_after_ovf got=%0d exp=6", count_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL fill_ovf_pulse got=%0b exp=0", ovf_o); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 6; i++) begin
      tests_run++; if (empty_o !== 1'b0) begin fails++; $display("FAIL drain_empty_%0d got=%0b exp=0", i, empty_o); end
      tests_run++; if (dout_o !== 32'(i)) begin fails++; $display("FAIL drain_dout_%0d got=%0h exp=%0h", i, dout_o, i); end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
    end
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL drain_empty_end got=%0b exp=1", empty_o); end
    tests_run++; if (count_o !== 4'd0) begin fails++; $display("FAIL drain_count_end got=%0d exp=0", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++; if (unf_o !== 1'b1) begin fails++; $display("FAIL drain_unf got=%0b exp=1", unf_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (unf_o !== 1'b0) begin fails++; $display("FAIL drain_unf_pulse got=%0b exp=0", unf_o); end
  endtask

  task automatic test_stream();
    logic [DBITS-1:0] exp_d;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (count_o !== 4'd3) begin fails++; $display("FAIL stream_prefill got=%0d exp=3", count_o); end
    for (int i = 0; i < 100; i++) begin
      exp_d = 32'h1000 + 32'(i);
      tests_run++; if (empty_o !== 1'b0 || dout_o !== exp_d) begin fails++; $display("FAIL stream_dout_%0d got=%0h empty=%0b exp=%0h", i, dout_o, empty_o, exp_d); end
      drive(1'b1, 32'h1003 + 32'(i), 1'b1, 1'b0);
      tests_run++; if (count_o !== 4'd3) begin fails++; $display("FAIL stream_count_%0d got=%0d exp=3", i, count_o); end
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    tests_run++; if (count_o !== 4'd3) begin fails++; $display("FAIL clear_pre_count got=%0d exp=3", count_o); end
    drive(1'b1, 32'h99, 1'b1, 1'b1);
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL clear_empty got=%0b exp=1", empty_o); end
    tests_run++; if (count_o !== 4'd0) begin fails++; $display("FAIL clear_count got=%0d exp=0", count_o); end
    tests_run++; if (full_o !== 1'b0) begin fails++; $display("FAIL clear_full got=%0b exp=0", full_o); end
    tests_run++; if (dout_o !== 32'h11) begin fails++; $display("FAIL clear_dout_hold got=%0h exp=11", dout_o); end
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    tests_run++; if (empty_o !== 1'b1 || count_o !== 4'd1) begin fails++; $display("FAIL clear_push_n1 got empty=%0b count=%0d exp empty=1 count=1", empty_o, count_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (empty_o !== 1'b0 || dout_o !== 32'h55) begin fails++; $display("FAIL clear_push_dout got=%0h empty=%0b exp=55", dout_o, empty_o); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hB1, 1'b0, 1'b0);
    drive(1'b1, 32'hB2, 1'b0, 1'b0);
    #3 rst_ni = 1'b0;
    #1;
    tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL arst_empty got=%0b exp=1", empty_o); end
    tests_run++; if (count_o !== 4'd0) begin fails++; $display("FAIL arst_count got=%0d exp=0", count_o); end
    tests_run++; if (full_o !== 1'b0 || dout_o !== 32'h0) begin fails++; $display("FAIL arst_full_dout got full=%0b dout=%0h exp 0/0", full_o, dout_o); end
    q.delete();
    @(posedge clk); #4;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests_run++; if (empty_o !== 1'b1 || count_o !== 4'd0) begin fails++; $display("FAIL arst_stale_%0d got empty=%0b count=%0d exp 1/0", i, empty_o, count_o); end
    end
    drive(1'b1, 32'hC3, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (dout_o !== 32'hC3 || count_o !== 4'd1) begin fails++; $display("FAIL arst_after got dout=%0h count=%0d exp c3/1", dout_o, count_o); end
  endtask

  task automatic test_random();
    logic p, po, c;
    int idle_run;
    idle_run = 0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if ((i / 50) % 2 == 0) begin
        p = ($urandom_range(0, 99) < 65); po = ($urandom_range(0, 99) < 35);
      end else begin
        p = ($urandom_range(0, 99) < 35); po = ($urandom_range(0, 99) < 65);
      end
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) begin p = 1'b0; po = 1'b0; c = 1'b0; end
      drive(p, $urandom, po, c);
      idle_run = (p || po || c) ? 0 : idle_run + 1;
      tests_run++; if (count_o !== 4'(q.size())) begin fails++; $display("FAIL rnd_count_%0d got=%0d exp=%0d", i, count_o, q.size()); end
      tests_run++; if (ovf_o !== exp_ovf || unf_o !== exp_unf) begin fails++; $display("FAIL rnd_pulse_%0d got=%0b%0b exp=%0b%0b", i, ovf_o, unf_o, exp_ovf, exp_unf); end
      if (!empty_o) begin
        tests_run++;
        if (q.size() == 0) begin fails++; $display("FAIL rnd_phantom_%0d got=%0h exp=empty", i, dout_o); end
        else if (dout_o !== q[0]) begin fails++; $display("FAIL rnd_dout_%0d got=%0h exp=%0h", i, dout_o, q[0]); end
      end
      if (q.size() == 0) begin
        tests_run++; if (empty_o !== 1'b1) begin fails++; $display("FAIL rnd_empty_%0d got=%0b exp=1", i, empty_o); end
      end
      if (q.size() < 4) begin
        tests_run++; if (full_o !== 1'b0) begin fails++; $display("FAIL rnd_full_low_%0d got=%0b exp=0", i, full_o); end
      end
      if (q.size() == 6) begin
        tests_run++; if (full_o !== 1'b1) begin fails++; $display("FAIL rnd_full_high_%0d got=%0b exp=1", i, full_o); end
      end
      if (idle_run >= 2 && q.size() > 0) begin
        tests_run++; if (empty_o !== 1'b0) begin fails++; $display("FAIL rnd_settle_%0d got=%0b exp=0", i, empty_o); end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_push();
    test_fill();
    test_drain();
    test_stream();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
